// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory arbiter: FSM state encoding,
// default SRAM word-address width and performance counter slot indices.
`timescale 1ns/1ps
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_I_WAIT = 3'd1,
        ST_I_RESP = 3'd2,
        ST_D_WAIT = 3'd3,
        ST_D_RESP = 3'd4
    } arb_state_t;

    localparam int NUM_CNT    = 4;
    localparam int CNT_IFETCH = 0;
    localparam int CNT_DREAD  = 1;
    localparam int CNT_DWRITE = 2;
    localparam int CNT_STALL  = 3;

endpackage

// File: rtl/arb_perf_cnt.sv
// Bank of free-running 32-bit event counters, one increment strobe each;
// counters wrap naturally at 2^32.
`timescale 1ns/1ps
module arb_perf_cnt
    import mips_mem_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CNT-1:0]       i_inc,
    output logic [NUM_CNT-1:0][31:0] o_cnt
);

    logic [NUM_CNT-1:0][31:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (i_inc[i]) r_cnt[i] <= r_cnt[i] + 32'd1;
            end
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates CPU instruction fetches and data accesses onto one single-port
// synchronous SRAM. Define ARB_PERF_CNT_EN to build the performance counters.
//
// Handshake: a request is accepted in the cycle its Ack is high (IDLE only);
// a response is transferred in every cycle where Valid and its Ack are both high.
`timescale 1ns/1ps
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PC,
    input  logic              Inst_Req_Valid,
    output logic              Inst_Req_Ack,
    output logic [31:0]       Instruction,
    output logic              Inst_Valid,
    input  logic              Inst_Ack,
    input  logic [31:0]       Address,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [31:0]       Write_data,
    input  logic [3:0]        Write_strb,
    output logic              Mem_Req_Ack,
    output logic [31:0]       Read_data,
    output logic              Read_data_Valid,
    input  logic              Read_data_Ack,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       arb_perf_cnt_0,
    output logic [31:0]       arb_perf_cnt_1,
    output logic [31:0]       arb_perf_cnt_2,
    output logic [31:0]       arb_perf_cnt_3,
    output arb_state_t        o_dbg_state
);

    arb_state_t  r_state;
    logic [31:0] r_buf;
    logic        r_inst_valid;
    logic        r_data_valid;

    logic w_wr_sel;
    logic w_rd_sel;
    logic w_if_sel;
    logic w_unused_addr_bits;

    // Fixed priority: write beats read beats fetch; only IDLE accepts.
    always_comb begin
        w_wr_sel = 1'b0;
        w_rd_sel = 1'b0;
        w_if_sel = 1'b0;
        if (r_state == ST_IDLE) begin
            w_wr_sel = MemWrite;
            w_rd_sel = !MemWrite && MemRead;
            w_if_sel = !MemWrite && !MemRead && Inst_Req_Valid;
        end
    end

    assign Mem_Req_Ack  = w_wr_sel | w_rd_sel;
    assign Inst_Req_Ack = w_if_sel;

    assign ram_en    = w_wr_sel | w_rd_sel | w_if_sel;
    assign ram_we    = w_wr_sel ? Write_strb : 4'b0000;
    assign ram_addr  = w_if_sel ? PC[ADDR_W+1:2] : Address[ADDR_W+1:2];
    assign ram_wdata = w_wr_sel ? Write_data : 32'd0;

    // Byte offset and bits beyond the SRAM size are intentionally dropped.
    assign w_unused_addr_bits = ^{PC[31:ADDR_W+2], PC[1:0],
                                  Address[31:ADDR_W+2], Address[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_buf        <= 32'd0;
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_sel)      r_state <= ST_D_WAIT;
                    else if (w_if_sel) r_state <= ST_I_WAIT;
                end
                ST_I_WAIT: begin
                    r_buf        <= ram_rdata;
                    r_inst_valid <= 1'b1;
                    r_state      <= ST_I_RESP;
                end
                ST_D_WAIT: begin
                    r_buf        <= ram_rdata;
                    r_data_valid <= 1'b1;
                    r_state      <= ST_D_RESP;
                end
                ST_I_RESP: begin
                    if (Inst_Ack) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_D_RESP: begin
                    if (Read_data_Ack) begin
                        r_data_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_inst_valid <= 1'b0;
                    r_data_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign Instruction     = r_buf;
    assign Read_data       = r_buf;
    assign Inst_Valid      = r_inst_valid;
    assign Read_data_Valid = r_data_valid;
    assign o_dbg_state     = r_state;

`ifdef ARB_PERF_CNT_EN
    logic [NUM_CNT-1:0]       w_cnt_inc;
    logic [NUM_CNT-1:0][31:0] w_cnt;

    // A held request that is not acked this cycle is a stall cycle.
    always_comb begin
        w_cnt_inc             = '0;
        w_cnt_inc[CNT_IFETCH] = w_if_sel;
        w_cnt_inc[CNT_DREAD]  = w_rd_sel;
        w_cnt_inc[CNT_DWRITE] = w_wr_sel;
        w_cnt_inc[CNT_STALL]  = (MemWrite | MemRead | Inst_Req_Valid) && !ram_en;
    end

    arb_perf_cnt u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_cnt_inc),
        .o_cnt (w_cnt)
    );

    assign arb_perf_cnt_0 = w_cnt[CNT_IFETCH];
    assign arb_perf_cnt_1 = w_cnt[CNT_DREAD];
    assign arb_perf_cnt_2 = w_cnt[CNT_DWRITE];
    assign arb_perf_cnt_3 = w_cnt[CNT_STALL];
`else
    assign arb_perf_cnt_0 = 32'd0;
    assign arb_perf_cnt_1 = 32'd0;
    assign arb_perf_cnt_2 = 32'd0;
    assign arb_perf_cnt_3 = 32'd0;
`endif

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 14, SRAM word-address width (64 KiB).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 PC  input  32  CPU instruction byte address; Inst_Req_Valid  input  1  fetch request; Inst_Req_Ack  output  1  fetch accepted.
REQ-005 Instruction  output  32  fetched word; Inst_Valid  output  1  word valid; Inst_Ack  input  1  CPU consumed word.
REQ-006 Address  input  32  data byte address; MemWrite  input  1; MemRead  input  1; Write_data  input  32; Write_strb  input  4  byte enables; Mem_Req_Ack  output  1  data request accepted.
REQ-007 Read_data  output  32; Read_data_Valid  output  1; Read_data_Ack  input  1.
REQ-008 ram_en  output  1; ram_we  output  4; ram_addr  output  ADDR_W; ram_wdata  output  32; ram_rdata  input  32, valid the cycle after ram_en (single-port synchronous SRAM).
REQ-009 arb_perf_cnt_0..3  output  32 each  performance counters.

Function
REQ-010 FSM states: IDLE, I_WAIT, I_RESP, D_WAIT, D_RESP.
REQ-011 In IDLE, priority: MemWrite > MemRead > Inst_Req_Valid; fixed, no fairness.
REQ-012 Ack outputs combinational, asserted only in IDLE for the selected request, one cycle per accepted request.
REQ-013 Write accept: ram_en=1, ram_we=Write_strb, ram_wdata=Write_data, ram_addr=Address[ADDR_W+1:2], Mem_Req_Ack=1; stays IDLE; no response.
REQ-014 Read accept (data or inst) at cycle T: ram_en=1, ram_we=0, address from Address or PC bits [ADDR_W+1:2]; next state D_WAIT/I_WAIT.
REQ-015 WAIT state (T+1): ram_rdata registered into response buffer; next state D_RESP/I_RESP.
REQ-016 RESP state: Read_data_Valid/Inst_Valid high from T+2, buffer held stable until matching Ack sampled high; then IDLE; new request acceptable the cycle after the Ack.
REQ-017 Read_data and Instruction both driven from the shared buffer; only the matching Valid asserts.
REQ-018 MemRead and MemWrite both high: treated as write; read ignored.
REQ-019 Address bits [1:0] and above ADDR_W+1 ignored; addresses wrap modulo SRAM size.
REQ-020 Write_strb=0 with MemWrite: accepted and acked, no byte changed.
REQ-021 Unselected request in IDLE receives no Ack and is served on a later IDLE cycle if still held.
REQ-022 ram_en=0, ram_we=0 in every non-accept cycle.

Reset
REQ-023 On rst: state IDLE, buffer 0, all Valid/Ack 0, ram_en=0, ram_we=0, counters 0.
REQ-024 Reset mid-transaction discards the in-flight read; no Valid after release until a new request.

Configuration
REQ-025 Macro ARB_PERF_CNT_EN defined: cnt_0 instruction fetches accepted, cnt_1 data reads accepted, cnt_2 data writes accepted, cnt_3 cycles any request held but not acked; all wrap at 2^32.
REQ-026 Macro undefined: counters not instantiated, arb_perf_cnt_0..3 tied 0.

Structure
REQ-027 Shared package mips_mem_pkg: FSM state enum, ADDR_W default, counter index constants.
REQ-028 One sub-module arb_perf_cnt (four wrapping counters with increment strobes), instantiated only under ARB_PERF_CNT_EN.

Verification
REQ-029 Fetch PC=0x10, SRAM word 4=0x2402_0005, Inst_Ack immediate -> Inst_Req_Ack at T, Inst_Valid at T+2 with 0x2402_0005, IDLE at T+3.
REQ-030 Write Address=0x20, Write_data=0xAABB_CCDD, Write_strb=4'b0101 onto 0 then read 0x20 -> Read_data=0x00BB_00DD.
REQ-031 MemRead and Inst_Req_Valid same cycle -> Mem_Req_Ack first, Inst_Req_Ack only after Read_data_Ack, inst response correct.
REQ-032 Inst_Ack held low 5 cycles -> Inst_Valid and Instruction stable 5 cycles, no ram_en, new requests unacked.
REQ-033 rst pulsed in D_WAIT -> no Read_data_Valid after release; next fetch served normally.
REQ-034 ARB_PERF_CNT_EN, 3 fetches, 2 reads, 1 write -> counters 3/2/1, cnt_3 equals stalled cycles counted by bench; undefined -> all 0.
